// File: rtl/async_fifo_pkg.sv
// Shared types and helpers for the AsyncFIFO write-port arbiter.
package async_fifo_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_t;

   localparam int unsigned NREQ_MAX     = 16;
   localparam int unsigned IDX_W_MAX    = 4;
   localparam int unsigned NREQ_DEF     = 4;
   localparam int unsigned DSIZE_DEF    = 32;
   localparam int unsigned MAXBURST_DEF = 8;
   localparam int unsigned GNT_W        = $clog2(NREQ_DEF);

   // First set bit of valid scanning ptr, ptr+1, ... modulo n; returns ptr when none set.
   function automatic int unsigned rr_pick(input logic [NREQ_MAX-1:0] valid,
                                           input int unsigned        ptr,
                                           input int unsigned        n);
      int unsigned idx;
      logic        found;
      rr_pick = ptr;
      found   = 1'b0;
      for (int unsigned k = 0; k < NREQ_MAX; k++) begin
         idx = ptr + k;
         if (idx >= n) idx = idx - n;
         if (!found && (k < n) && valid[idx[IDX_W_MAX-1:0]]) begin
            rr_pick = idx;
            found   = 1'b1;
         end
      end
   endfunction

endpackage

// File: rtl/async_fifo_wr_arbiter_if.sv
// Requester beats plus the AsyncFIFO write port, bundled for the arbiter.
interface async_fifo_wr_arbiter_if
   import async_fifo_pkg::*;
#(
   parameter int unsigned NREQ  = NREQ_DEF,
   parameter int unsigned DSIZE = DSIZE_DEF
);
   localparam int unsigned ID_W = $clog2(NREQ);

   logic [NREQ-1:0]       req_valid;
   logic [NREQ*DSIZE-1:0] req_data;
   logic [NREQ-1:0]       req_last;
   logic [NREQ-1:0]       req_ready;
   logic                  winc;
   logic [DSIZE-1:0]      wdata;
   logic                  wfull;
   logic                  gnt_valid;
   logic [ID_W-1:0]       gnt_id;

   modport master (
      output req_valid, req_data, req_last, wfull,
      input  req_ready, winc, wdata, gnt_valid, gnt_id
   );

   modport slave (
      input  req_valid, req_data, req_last, wfull,
      output req_ready, winc, wdata, gnt_valid, gnt_id
   );

endinterface

// File: rtl/rr_arbiter_core.sv
// Round-robin pointer and pick logic; the pointer moves past the owner on advance.
module rr_arbiter_core
   import async_fifo_pkg::*;
#(
   parameter int unsigned NREQ = NREQ_DEF,
   parameter int unsigned ID_W = $clog2(NREQ)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NREQ-1:0] valid,
   input  logic            advance,
   input  logic [ID_W-1:0] owner,
   output logic            pick_valid,
   output logic [ID_W-1:0] pick_id
);

   logic [ID_W-1:0] rr_ptr;

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr <= '0;
      end else if (advance) begin
         rr_ptr <= (owner == ID_W'(NREQ - 1)) ? '0 : ID_W'(owner + 1'b1);
      end
   end

   always_comb begin
      pick_valid = |valid;
      pick_id    = ID_W'(rr_pick(NREQ_MAX'(valid), 32'(rr_ptr), NREQ));
   end

endmodule

// File: rtl/async_fifo_wr_arbiter.sv
// Shares the AsyncFIFO write port among NREQ requesters with packet-locked round-robin grants.
module async_fifo_wr_arbiter
   import async_fifo_pkg::*;
#(
   parameter int unsigned NREQ     = NREQ_DEF,
   parameter int unsigned DSIZE    = DSIZE_DEF,
   parameter int unsigned MAXBURST = MAXBURST_DEF
) (
   input logic                    clk,
   input logic                    rst,
   async_fifo_wr_arbiter_if.slave bus
);

   localparam int unsigned ID_W  = $clog2(NREQ);
   localparam int unsigned CNT_W = $clog2(MAXBURST) + 1;

   arb_state_t        state_q, state_d;
   logic [ID_W-1:0]   gnt_q, gnt_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              gv_q, gv_d;

   logic              pick_valid;
   logic [ID_W-1:0]   pick_id;
   logic              advance;

   logic              own_valid;
   logic              own_last;
   logic [DSIZE-1:0]  own_data;
   logic              accept;
   logic [NREQ-1:0]   ready;

   rr_arbiter_core #(
      .NREQ (NREQ),
      .ID_W (ID_W)
   ) u_core (
      .clk        (clk),
      .rst        (rst),
      .valid      (bus.req_valid),
      .advance    (advance),
      .owner      (gnt_q),
      .pick_valid (pick_valid),
      .pick_id    (pick_id)
   );

   // Owner's beat, selected by the registered grant.
   always_comb begin
      own_valid = 1'b0;
      own_last  = 1'b0;
      own_data  = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (ID_W'(i) == gnt_q) begin
            own_valid = bus.req_valid[i];
            own_last  = bus.req_last[i];
            own_data  = bus.req_data[i*DSIZE +: DSIZE];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      cnt_d   = cnt_q;
      advance = 1'b0;
      accept  = 1'b0;
      ready   = '0;

      case (state_q)
         IDLE: begin
            if (pick_valid) begin
               gnt_d   = pick_id;
               cnt_d   = '0;
               state_d = GRANT;
            end
         end
         GRANT: begin
            for (int i = 0; i < NREQ; i++) begin
               ready[i] = (ID_W'(i) == gnt_q) & ~bus.wfull & ~rst;
            end
            accept = own_valid & ~bus.wfull & ~rst;
            if (accept) begin
               // Packet end or burst cap releases the port; the pointer moves past the owner.
               if (own_last || (cnt_q == CNT_W'(MAXBURST - 1))) begin
                  state_d = IDLE;
                  advance = 1'b1;
               end else begin
                  cnt_d = CNT_W'(cnt_q + 1'b1);
               end
            end
         end
         default: state_d = IDLE;
      endcase

      gv_d = (state_d == GRANT);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         cnt_q   <= '0;
         gv_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         cnt_q   <= cnt_d;
         gv_q    <= gv_d;
      end
   end

   assign bus.req_ready = ready;
   assign bus.winc      = accept;
   assign bus.wdata     = own_data;
   assign bus.gnt_valid = gv_q;
   assign bus.gnt_id    = gnt_q;

endmodule

// File: tb/tb_async_fifo_wr_arbiter.sv
// Directed vector table plus hand sequences for the AsyncFIFO write-port arbiter.
module tb_async_fifo_wr_arbiter;

   typedef struct packed {
      logic [3:0] valid;
      logic [3:0] last;
      logic       wfull;
      logic [7:0] seq;
      logic [3:0] rdy;
      logic       winc;
      logic       gv;
      logic [1:0] gid;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   vec_t tbl [24];

   always #5 clk = ~clk;

   async_fifo_wr_arbiter_if #(.NREQ(4), .DSIZE(32)) bus ();

   async_fifo_wr_arbiter #(
      .NREQ     (4),
      .DSIZE    (32),
      .MAXBURST (8)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   function automatic logic [31:0] word(input int id, input logic [7:0] s);
      return {8'(id), 16'h0000, s};
   endfunction

   function automatic vec_t mk(input logic [3:0] v, input logic [3:0] l, input logic wf,
                               input logic [7:0] s, input logic [3:0] rdy, input logic wi,
                               input logic gv, input logic [1:0] gid);
      vec_t t;
      t.valid = v; t.last = l; t.wfull = wf; t.seq = s;
      t.rdy = rdy; t.winc = wi; t.gv = gv; t.gid = gid;
      return t;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic check_out(input string nm, input logic [3:0] rdy, input logic wi,
                            input logic gv, input logic [1:0] gid, input logic [31:0] wd);
      chk({nm, " req_ready"}, 32'(bus.req_ready), 32'(rdy));
      chk({nm, " winc"},      32'(bus.winc),      32'(wi));
      chk({nm, " gnt_valid"}, 32'(bus.gnt_valid), 32'(gv));
      chk({nm, " gnt_id"},    32'(bus.gnt_id),    32'(gid));
      if (wi) chk({nm, " wdata"}, bus.wdata, wd);
   endtask

   task automatic set_data(input int i, input logic [7:0] s);
      bus.req_data[i*32 +: 32] = word(i, s);
   endtask

   task automatic drive(input logic [3:0] v, input logic [3:0] l, input logic wf);
      bus.req_valid = v;
      bus.req_last  = l;
      bus.wfull     = wf;
   endtask

   initial begin
      logic [1:0]  prev;
      logic [1:0]  order [5];
      logic [31:0] fifo [$];
      logic [31:0] w;
      int          cnt [3];
      int          rd_exp [3];
      int          nread;
      int          cyc;
      bit          stall_seen;
      logic [3:0]  acc;

      // Single requester, single-beat, owner drop, backpressure.
      tbl[0]  = mk(4'b0010, 4'b0000, 1'b0, 8'h0A, 4'b0000, 1'b0, 1'b0, 2'd0);
      tbl[1]  = mk(4'b0010, 4'b0000, 1'b0, 8'h0A, 4'b0010, 1'b1, 1'b1, 2'd1);
      tbl[2]  = mk(4'b0010, 4'b0000, 1'b0, 8'h0B, 4'b0010, 1'b1, 1'b1, 2'd1);
      tbl[3]  = mk(4'b0010, 4'b0010, 1'b0, 8'h0C, 4'b0010, 1'b1, 1'b1, 2'd1);
      tbl[4]  = mk(4'b0000, 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0, 1'b0, 2'd1);
      tbl[5]  = mk(4'b1000, 4'b1000, 1'b0, 8'h20, 4'b0000, 1'b0, 1'b0, 2'd1);
      tbl[6]  = mk(4'b1000, 4'b1000, 1'b0, 8'h20, 4'b1000, 1'b1, 1'b1, 2'd3);
      tbl[7]  = mk(4'b0000, 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0, 1'b0, 2'd3);
      tbl[8]  = mk(4'b0001, 4'b0000, 1'b0, 8'h30, 4'b0000, 1'b0, 1'b0, 2'd3);
      tbl[9]  = mk(4'b0001, 4'b0000, 1'b0, 8'h30, 4'b0001, 1'b1, 1'b1, 2'd0);
      tbl[10] = mk(4'b1110, 4'b0000, 1'b0, 8'h31, 4'b0001, 1'b0, 1'b1, 2'd0);
      tbl[11] = mk(4'b1110, 4'b0000, 1'b0, 8'h31, 4'b0001, 1'b0, 1'b1, 2'd0);
      tbl[12] = mk(4'b1111, 4'b0001, 1'b0, 8'h31, 4'b0001, 1'b1, 1'b1, 2'd0);
      tbl[13] = mk(4'b0000, 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0, 1'b0, 2'd0);
      tbl[14] = mk(4'b0100, 4'b0000, 1'b0, 8'h40, 4'b0000, 1'b0, 1'b0, 2'd0);
      tbl[15] = mk(4'b0100, 4'b0000, 1'b0, 8'h40, 4'b0100, 1'b1, 1'b1, 2'd2);
      for (int r = 16; r <= 20; r++)
         tbl[r] = mk(4'b0100, 4'b0000, 1'b1, 8'h41, 4'b0000, 1'b0, 1'b1, 2'd2);
      tbl[21] = mk(4'b0100, 4'b0000, 1'b0, 8'h41, 4'b0100, 1'b1, 1'b1, 2'd2);
      tbl[22] = mk(4'b0100, 4'b0100, 1'b0, 8'h42, 4'b0100, 1'b1, 1'b1, 2'd2);
      tbl[23] = mk(4'b0000, 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0, 1'b0, 2'd2);

      bus.req_data = '0;
      drive(4'b0000, 4'b0000, 1'b0);

      // Reset with all requesters asserting.
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         drive(4'b1111, 4'b1111, 1'b0);
         #2 check_out("reset", 4'b0000, 1'b0, 1'b0, 2'd0, 32'h0);
      end
      @(negedge clk);
      rst = 1'b0;
      drive(4'b0000, 4'b0000, 1'b0);

      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         #2 check_out("idle", 4'b0000, 1'b0, 1'b0, 2'd0, 32'h0);
      end

      for (int r = 0; r < 24; r++) begin
         @(negedge clk);
         drive(tbl[r].valid, tbl[r].last, tbl[r].wfull);
         for (int i = 0; i < 4; i++) set_data(i, tbl[r].seq);
         #2 check_out($sformatf("vec%0d", r), tbl[r].rdy, tbl[r].winc, tbl[r].gv,
                      tbl[r].gid, word(int'(tbl[r].gid), tbl[r].seq));
      end

      // Round robin with everyone pending; pointer sits at 3 here.
      order = '{2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
      prev  = 2'd2;
      for (int g = 0; g < 5; g++) begin
         @(negedge clk);
         drive(4'b1111, 4'b0000, 1'b0);
         for (int i = 0; i < 4; i++) set_data(i, 8'(8'h60 + 2*g));
         #2 check_out($sformatf("rr%0d idle", g), 4'b0000, 1'b0, 1'b0, prev, 32'h0);
         for (int b = 0; b < 2; b++) begin
            @(negedge clk);
            drive(4'b1111, (b == 1) ? 4'b1111 : 4'b0000, 1'b0);
            for (int i = 0; i < 4; i++) set_data(i, 8'(8'h60 + 2*g + b));
            #2 check_out($sformatf("rr%0d beat%0d", g, b), 4'(1 << order[g]), 1'b1, 1'b1,
                         order[g], word(int'(order[g]), 8'(8'h60 + 2*g + b)));
         end
         prev = order[g];
      end

      // Forced split: req0 12 beats against a pending req3 packet.
      @(negedge clk);
      drive(4'b0001, 4'b0000, 1'b0);
      set_data(0, 8'd0);
      #2 check_out("split idle0", 4'b0000, 1'b0, 1'b0, 2'd3, 32'h0);
      for (int b = 0; b < 8; b++) begin
         @(negedge clk);
         drive(4'b1001, 4'b0000, 1'b0);
         set_data(0, 8'(b));
         set_data(3, 8'h50);
         #2 check_out($sformatf("split a%0d", b), 4'b0001, 1'b1, 1'b1, 2'd0, word(0, 8'(b)));
      end
      @(negedge clk);
      drive(4'b1001, 4'b0000, 1'b0);
      set_data(0, 8'd8);
      #2 check_out("split idle1", 4'b0000, 1'b0, 1'b0, 2'd0, 32'h0);
      for (int b = 0; b < 2; b++) begin
         @(negedge clk);
         drive(4'b1001, (b == 1) ? 4'b1000 : 4'b0000, 1'b0);
         set_data(3, 8'(8'h50 + b));
         #2 check_out($sformatf("split r3_%0d", b), 4'b1000, 1'b1, 1'b1, 2'd3,
                      word(3, 8'(8'h50 + b)));
      end
      @(negedge clk);
      drive(4'b0001, 4'b0000, 1'b0);
      #2 check_out("split idle2", 4'b0000, 1'b0, 1'b0, 2'd3, 32'h0);
      for (int b = 8; b < 12; b++) begin
         @(negedge clk);
         drive(4'b0001, (b == 11) ? 4'b0001 : 4'b0000, 1'b0);
         set_data(0, 8'(b));
         #2 check_out($sformatf("split b%0d", b), 4'b0001, 1'b1, 1'b1, 2'd0, word(0, 8'(b)));
      end
      @(negedge clk);
      drive(4'b0000, 4'b0000, 1'b0);
      #2 check_out("split done", 4'b0000, 1'b0, 1'b0, 2'd0, 32'h0);

      // Reset in the middle of a packet truncates it and rewinds the pointer.
      @(negedge clk);
      drive(4'b0010, 4'b0000, 1'b0);
      set_data(1, 8'h70);
      #2 check_out("mrst idle", 4'b0000, 1'b0, 1'b0, 2'd0, 32'h0);
      @(negedge clk);
      #2 check_out("mrst beat", 4'b0010, 1'b1, 1'b1, 2'd1, word(1, 8'h70));
      @(negedge clk);
      rst = 1'b1;
      #2 check_out("mrst hold", 4'b0000, 1'b0, 1'b1, 2'd1, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      drive(4'b0000, 4'b0000, 1'b0);
      #2 check_out("mrst after", 4'b0000, 1'b0, 1'b0, 2'd0, 32'h0);
      @(negedge clk);
      drive(4'b0101, 4'b0000, 1'b0);
      for (int i = 0; i < 4; i++) set_data(i, 8'h71);
      #2 check_out("mrst rearb", 4'b0000, 1'b0, 1'b0, 2'd0, 32'h0);
      @(negedge clk);
      drive(4'b0101, 4'b0101, 1'b0);
      #2 check_out("mrst ptr0", 4'b0001, 1'b1, 1'b1, 2'd0, word(0, 8'h71));
      @(negedge clk);
      drive(4'b0000, 4'b0000, 1'b0);
      #2 check_out("mrst end", 4'b0000, 1'b0, 1'b0, 2'd0, 32'h0);

      // End to end against a 16-deep FIFO model drained every third cycle.
      cnt = '{0, 0, 0};
      rd_exp = '{0, 0, 0};
      nread = 0;
      stall_seen = 1'b0;
      cyc = 0;
      while (nread < 30 && cyc < 3000) begin
         @(negedge clk);
         if ((cyc % 3) == 0 && fifo.size() > 0) begin
            w = fifo.pop_front();
            nread++;
            if (w[31:16] < 16'd3) begin
               chk($sformatf("e2e seq id%0d", w[31:16]), 32'(w[15:0]), 32'(rd_exp[w[31:16]]));
               rd_exp[w[31:16]]++;
            end else begin
               chk("e2e id", 32'(w[31:16]), 32'd0);
            end
         end
         bus.wfull = (fifo.size() >= 16);
         bus.req_valid[3] = 1'b0;
         bus.req_last[3]  = 1'b0;
         for (int i = 0; i < 3; i++) begin
            bus.req_valid[i] = (cnt[i] < 10);
            bus.req_last[i]  = ((cnt[i] % 3) == 2) || (cnt[i] == 9);
            bus.req_data[i*32 +: 32] = {16'(i), 16'(cnt[i])};
         end
         #2;
         if (bus.wfull && (|bus.req_valid[2:0])) stall_seen = 1'b1;
         acc = bus.req_valid & bus.req_ready;
         chk("e2e winc", 32'(bus.winc), 32'(|acc));
         if (bus.winc) fifo.push_back(bus.wdata);
         for (int i = 0; i < 3; i++) if (acc[i]) cnt[i]++;
         cyc++;
      end
      chk("e2e words read", 32'(nread), 32'd30);
      chk("e2e stall seen", 32'(stall_seen), 32'd1);
      chk("e2e fifo empty", 32'(fifo.size()), 32'd0);
      for (int i = 0; i < 3; i++) chk($sformatf("e2e last seq id%0d", i), 32'(rd_exp[i]), 32'd10);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
